// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment scanner with anti-ghost blanking, frame-synchronous
// shadowing of the display word, per-digit blink and decimal-point control.
module seg_scan #(
  parameter int DIGIT_CYC    = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Data,
  input  logic        Disp_en,
  input  logic [7:0]  Blink_mask,
  input  logic [7:0]  Dp_mask,
  output logic [7:0]  Sel,
  output logic [7:0]  Seg
);

  localparam int CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [31:0]   SHOW_LIM = 32'(DIGIT_CYC - BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  logic          slot_end, frame_end, lit;
  logic [3:0]    nib;

  // Active-low {dp,g,f,e,d,c,b,a}; non-decimal nibbles render as a dash.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hBF;
    endcase
  endfunction

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 3'd7);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    shadow_d  = frame_end ? Data : shadow_q;
    frm_d     = frm_q;
    phase_d   = phase_q;
    if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d   = frm_q + 1'b1;
      end
    end

    // Blink-off slots and disabled display look exactly like the blank tail of a slot.
    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    lit   = ({{(32-CW){1'b0}}, cnt_q} < SHOW_LIM) && Disp_en &&
            !(phase_q && Blink_mask[idx_q]);
    sel_d = lit ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d = lit ? (glyph(nib) & ~{Dp_mask[idx_q], 7'd0}) : 8'hFF;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'd0;
      frm_q    <= '0;
      phase_q  <= 1'b0;
      sel_q    <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
    end
  end

  assign Sel = sel_q;
  assign Seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a time-indexed display model predicts Sel/Seg per edge.
module tb_seg_scan;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Data;
  logic        Disp_en;
  logic [7:0]  Blink_mask;
  logic [7:0]  Dp_mask;
  logic [7:0]  Sel;
  logic [7:0]  Seg;

  seg_scan #(.DIGIT_CYC(DC), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset(Reset), .Data(Data), .Disp_en(Disp_en),
    .Blink_mask(Blink_mask), .Dp_mask(Dp_mask), .Sel(Sel), .Seg(Seg)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int t = 0;
  logic [31:0] m_shadow = 32'd0;
  logic [15:0] sb[$];
  logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; predicts the next rising edge.
  task automatic step();
    int slot, idx, frame, phase;
    logic [7:0] es, eg;
    logic [31:0] nxt;
    logic [15:0] exp;
    slot  = t % DC;
    idx   = (t / DC) % 8;
    frame = t / (DC * 8);
    phase = (frame / BF) % 2;
    if (!Disp_en || slot >= DC - BC || (phase == 1 && Blink_mask[idx])) begin
      es = 8'hFF;
      eg = 8'hFF;
    end else begin
      es = ~(8'd1 << idx);
      eg = GLYPH[m_shadow[4*idx +: 4]];
      if (Dp_mask[idx]) eg[7] = 1'b0;
    end
    sb.push_back({es, eg});
    nxt = (slot == DC - 1 && idx == 7) ? Data : m_shadow;
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'd1, 16'd0);
    end else begin
      exp = sb.pop_front();
      chk("selseg", {Sel, Seg}, exp);
    end
    chk("sel_onehot", 16'($countones(~Sel) <= 1), 16'd1);
    m_shadow = nxt;
    t++;
    @(negedge Clk);
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Reset = 1'b0;
    t = 0;
    m_shadow = 32'd0;
    sb.delete();
  endtask

  initial begin
    Reset = 1'b1;
    Data = 32'h1209_2502;
    Disp_en = 1'b1;
    Blink_mask = 8'h00;
    Dp_mask = 8'h00;
    #1;
    chk("rst_init", {Sel, Seg}, 16'hFFFF);
    @(negedge Clk);
    release_reset();

    // Startup sequence, held word, then a mid-frame data change at digit 3 of frame 1.
    repeat (192) begin
      if (t == 88) Data = 32'h3109_2502;
      step();
    end

    // Asynchronous reset while a digit is lit.
    repeat (2) step();
    chk("pre_rst_lit", 16'(Sel == 8'hFF), 16'd0);
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_async", {Sel, Seg}, 16'hFFFF);
    @(posedge Clk);
    #1;
    chk("rst_hold", {Sel, Seg}, 16'hFFFF);
    release_reset();

    // Blink on digits 2-3 across six frames, with decimal point on an 8 in digit 0.
    Data = 32'h3109_2508;
    Dp_mask = 8'h01;
    Blink_mask = 8'h0C;
    repeat (384) step();

    // Dash glyph for a non-decimal nibble.
    Dp_mask = 8'h00;
    Blink_mask = 8'h00;
    Data = 32'h3109_250B;
    repeat (128) step();

    // Display disabled mid-slot for 20 cycles, counters keep running.
    repeat (13) step();
    Disp_en = 1'b0;
    repeat (20) step();
    Disp_en = 1'b1;
    repeat (100) step();

    // Random live controls and data.
    repeat (256) begin
      Data = $urandom;
      Dp_mask = 8'($urandom);
      Blink_mask = 8'($urandom);
      Disp_en = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DIGIT_CYC, 50000: clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYC, 500: anti-ghost blank cycles at the end of each slot; DIGIT_CYC > BLANK_CYC >= 0.
REQ-003 SHALL have parameter BLINK_FRAMES, 62: full scan frames per blink half-period; must be >= 1.
REQ-004 SHALL have port Clk, input, 1: the only clock; all logic is on the rising edge.
REQ-005 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port Data, input, 32: the packed 8-nibble display word from the calendar/clock counters; nibble k = Data[4k+3:4k] drives digit k.
REQ-007 SHALL have port Disp_en, input, 1: display enable; 0 = all digits dark.
REQ-008 SHALL have port Blink_mask, input, 8: bit k = 1 blinks digit k (edit-field highlight).
REQ-009 SHALL have port Dp_mask, input, 8: bit k = 1 lights the decimal point of digit k.
REQ-010 SHALL have port Sel, output, 8: active-low digit enables, one-hot-low or all high.
REQ-011 SHALL have port Seg, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-012 SHALL run a slot counter 0..DIGIT_CYC-1 and a digit index 0..7 that advances when the slot counter wraps; index 7 wraps to 0, which ends one frame.
REQ-013 SHALL split each slot into SHOW (counter < DIGIT_CYC-BLANK_CYC) and BLANK (remaining cycles); in BLANK, Sel=8'hFF and Seg=8'hFF.
REQ-014 SHALL, in SHOW, drive Sel with only bit [index] low and Seg = glyph(shadow nibble[index]).
REQ-015 SHALL register Sel and Seg, so they reflect the counter, index, shadow and control-input state of the previous clock (1-cycle latency).
REQ-016 SHALL hold a 32-bit shadow register that loads Data on the last cycle of each frame (index 7, counter DIGIT_CYC-1); Data changes mid-frame do not affect the current frame.
REQ-017 SHALL use this glyph table, with dp bit 1: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90, and 0xA..0xF=BF ('-').
REQ-018 SHALL clear Seg[7] when Dp_mask[index]=1 during SHOW.
REQ-019 SHALL toggle a blink phase bit on each frame end after every BLINK_FRAMES frames; when phase=1 and Blink_mask[index]=1, that slot behaves as BLANK.
REQ-020 SHALL drive Sel=FF and Seg=FF when Disp_en=0, while counters, shadow load and blink phase keep running; re-enable resumes at the current slot position.
REQ-021 SHALL sample Blink_mask, Dp_mask and Disp_en live each cycle, not via the shadow.
REQ-022 SHALL never assert more than one Sel bit low in any cycle.

Reset
REQ-023 SHALL, while Reset=1, asynchronously force Sel=8'hFF, Seg=8'hFF, slot counter=0, index=0, shadow=0 and blink phase=0.
REQ-024 SHALL start counting at slot 0, digit 0 on the first rising edge after Reset falls; the first frame shows the shadow value 0 (all digits C0).
REQ-025 SHALL apply reset mid-slot or mid-blink immediately, with no partial-slot completion.

Verification (DIGIT_CYC=8, BLANK_CYC=2, BLINK_FRAMES=2, Disp_en=1, masks=0 unless stated)
REQ-026 SHALL cover: Reset pulse mid-frame -> Sel=FF and Seg=FF within the same cycle; after release, outputs for edges 1-6 = FE/C0, edges 7-8 = FF/FF, edges 9-14 = FD/C0.
REQ-027 SHALL cover: Data=32'h1209_2502 held -> from the second frame, digits 0..7 show Seg A4,C0,92,A4,90,C0,A4,F9.
REQ-028 SHALL cover: Data changed from 32'h1209_2502 to 32'h3109_2502 at digit 3 mid-frame -> digit 7 still shows F9 that frame and shows B0 next frame.
REQ-029 SHALL cover: Blink_mask=8'h0C -> digits 2 and 3 show Sel=FF/Seg=FF in frames 2-3, visible in frames 0-1 and 4-5; other digits are unaffected.
REQ-030 SHALL cover: nibble 0 = 8 with Dp_mask=8'h01 -> Seg=00; nibble 0 = 0xB -> Seg=BF.
REQ-031 SHALL cover: Disp_en low for 20 cycles -> Sel/Seg=FF; on re-enable the next output continues at the free-running slot position, and no Sel bit other than the current index is ever low.
